// File: rtl/mult_sequencer.sv
// mult_sequencer: 64-bit MIPS mult/multu product computed with shift-add, using the shared 32-bit ALU as the only adder.
// Latency: fixed 37 cycles from the accepting edge to the done pulse, for both signed and unsigned operands.
// Backpressure: none; start is accepted only in IDLE, and a start seen while busy or done is dropped.
// Ports: clk/reset (sync, active-high); start/is_signed/op_a/op_b request; busy/done status;
//        hi/lo registered product; alu_in1/alu_in2/alu_ctl/alu_shamt drive the shared ALU, alu_out is its result.
module mult_sequencer #(
  parameter logic [3:0] ALU_ADD  = 4'd2,
  parameter logic [3:0] ALU_SUB  = 4'd6,
  parameter logic [3:0] ALU_NOR  = 4'd12,
  parameter logic [3:0] ALU_IDLE = 4'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_ctl,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_NEG_LO, S_NEG_HI, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [4:0]  count_q, count_d;
  logic        neg_res_q, neg_res_d;
  logic        lo_zero_q, lo_zero_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic        carry;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      count_q   <= '0;
      neg_res_q <= 1'b0;
      lo_zero_q <= 1'b0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      count_q   <= count_d;
      neg_res_q <= neg_res_d;
      lo_zero_q <= lo_zero_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
    end
  end

  // The ALU result wrapped iff it is below one of its addends.
  assign carry = (alu_out < hi_q);

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    count_d   = count_q;
    neg_res_d = neg_res_q;
    lo_zero_d = lo_zero_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    alu_in1   = '0;
    alu_in2   = '0;
    alu_ctl   = ALU_IDLE;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d   = op_a;
          lo_d      = op_b;
          hi_d      = '0;
          neg_res_d = is_signed & (op_a[31] ^ op_b[31]);
          sa_d      = is_signed & op_a[31];
          sb_d      = is_signed & op_b[31];
          state_d   = S_NEG_A;
        end
      end
      S_NEG_A: begin
        busy    = 1'b1;
        alu_in2 = mcand_q;
        alu_ctl = ALU_SUB;
        if (sa_q) mcand_d = alu_out;
        state_d = S_NEG_B;
      end
      S_NEG_B: begin
        busy    = 1'b1;
        alu_in2 = lo_q;
        alu_ctl = ALU_SUB;
        if (sb_q) lo_d = alu_out;
        count_d = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        busy    = 1'b1;
        alu_in1 = hi_q;
        alu_in2 = lo_q[0] ? mcand_q : 32'd0;
        alu_ctl = ALU_ADD;
        // Shift the 65-bit {carry, sum, multiplier} right by one.
        hi_d    = {carry, alu_out[31:1]};
        lo_d    = {alu_out[0], lo_q[31:1]};
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) state_d = S_NEG_LO;
      end
      S_NEG_LO: begin
        busy      = 1'b1;
        lo_zero_d = (lo_q == 32'd0);
        alu_in2   = lo_q;
        alu_ctl   = ALU_SUB;
        if (neg_res_q) lo_d = alu_out;
        state_d   = S_NEG_HI;
      end
      S_NEG_HI: begin
        busy = 1'b1;
        // 64-bit negate: the +1 only ripples into hi when lo was zero,
        // otherwise hi is just inverted (nor of hi with itself).
        if (lo_zero_q) begin
          alu_in2 = hi_q;
          alu_ctl = ALU_SUB;
        end else begin
          alu_in1 = hi_q;
          alu_in2 = hi_q;
          alu_ctl = ALU_NOR;
        end
        if (neg_res_q) hi_d = alu_out;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign alu_shamt = 5'd0;

endmodule
